// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// MEM-stage initiator for a word-addressed data memory. Accepts one
// byte/half/word load or store at a time and turns the byte address into a
// word index. Sub-word stores are done as read-modify-write. Sub-word loads
// are sign- or zero-extended. Misaligned, illegal-size and out-of-range
// requests return a fault and never touch memory.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_req_valid           request present
//   o_req_ready           unit can accept a request this cycle (IDLE only)
//   i_req_we              1 = store, 0 = load
//   i_req_size            00 byte, 01 half, 10 word, 11 illegal
//   i_req_signed          loads only: sign-extend when 1
//   i_req_addr            byte address
//   i_req_wdata           right-aligned store data
//   o_resp_valid          one-cycle completion pulse
//   o_resp_rdata          extended load result, 0 for stores/faults
//   o_resp_fault          fault flag, qualified by o_resp_valid
//   o_mem_addr            word index (captured address >> 2)
//   o_mem_rd / o_mem_wr   one-cycle memory read / write strobes
//   o_mem_wdata           full word written while o_mem_wr = 1
//   i_mem_rdata           read data, valid the cycle after o_mem_rd
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_WORDS      = 256,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_fault,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  // The RD -> CAP sequencing assumes read data one cycle after the strobe.
  if (MEM_RD_LATENCY != 1) begin : g_bad_latency
    $error("load_store_unit supports MEM_RD_LATENCY = 1 only");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic [1:0]  SZ_ILL   = 2'b11;
  localparam logic [29:0] LP_LIMIT = 30'(MEM_WORDS);

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_fault;
  logic [31:0] r_word;

  logic        w_accept;
  logic        w_fault;
  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_loaded;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  assign w_shift  = {r_addr[1:0], 3'b000};

  // Fault decode on the live request, so the decision is made on the accept edge.
  always_comb begin
    w_fault = 1'b0;
    if (i_req_size == SZ_ILL) begin
      w_fault = 1'b1;
    end
    if (i_req_size == SZ_HALF && i_req_addr[0]) begin
      w_fault = 1'b1;
    end
    if (i_req_size == SZ_WORD && i_req_addr[1:0] != 2'b00) begin
      w_fault = 1'b1;
    end
    if (i_req_addr[31:2] >= LP_LIMIT) begin
      w_fault = 1'b1;
    end
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  // A half at offset 2 uses shift 16, which the byte-offset shift already gives.
  always_comb begin
    w_lane   = i_mem_rdata >> w_shift;
    w_loaded = i_mem_rdata;
    w_mask   = 32'h0000_0000;
    case (r_size)
      SZ_BYTE: begin
        w_loaded = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
        w_mask   = 32'h0000_00FF << w_shift;
      end
      SZ_HALF: begin
        w_loaded = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
        w_mask   = 32'h0000_FFFF << w_shift;
      end
      default: begin
        w_loaded = i_mem_rdata;
        w_mask   = 32'hFFFF_FFFF;
      end
    endcase
    w_merged = (i_mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);
  end

  // State register plus request capture; reset discards any in-flight access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_fault  <= 1'b0;
      r_word   <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_fault  <= w_fault;
      end else if (r_state == S_CAP) begin
        r_word <= r_we ? w_merged : w_loaded;
      end
    end
  end

  // Next-state and Moore outputs. Word stores skip the read; faults go
  // straight to the response.
  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wdata  = 32'h0;
    o_resp_valid = 1'b0;
    o_resp_fault = 1'b0;
    o_resp_rdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = ~i_rst;
        if (i_req_valid) begin
          if (w_fault) begin
            w_next = S_RESP;
          end else if (i_req_we && i_req_size == SZ_WORD) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end
      end
      S_RD: begin
        o_mem_rd = 1'b1;
        w_next   = S_CAP;
      end
      S_CAP: begin
        w_next = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        o_mem_wr    = 1'b1;
        o_mem_wdata = (r_size == SZ_WORD) ? r_wdata : r_word;
        w_next      = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_fault = r_fault;
        o_resp_rdata = (r_we || r_fault) ? 32'h0 : r_word;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_mem_addr = {2'b00, r_addr[31:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Scoreboard bench for load_store_unit. A word memory model answers the DUT's
// strobes; a byte-array reference model predicts each response, which is
// queued at accept time and checked by an independent monitor when the DUT
// pulses resp_valid.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respFault;
  logic [31:0] memAddr;
  logic        memRd;
  logic        memWr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acceptCyc;
    int          rdCnt;
    int          wrCnt;
    logic [31:0] wordIdx;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          failures = 0;
  int          negCount = 0;
  int          rdSeen = 0;
  int          wrSeen = 0;

  logic [31:0] mem    [0:255];
  logic [7:0]  refMem [0:1023];
  logic        pokeEn = 1'b0;
  logic [7:0]  pokeIdx = 8'h0;
  logic [31:0] pokeVal = 32'h0;

  load_store_unit #(.MEM_WORDS(256), .MEM_RD_LATENCY(1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_req_we     (reqWe),
    .i_req_size   (reqSize),
    .i_req_signed (reqSigned),
    .i_req_addr   (reqAddr),
    .i_req_wdata  (reqWdata),
    .o_resp_valid (respValid),
    .o_resp_rdata (respRdata),
    .o_resp_fault (respFault),
    .o_mem_addr   (memAddr),
    .o_mem_rd     (memRd),
    .o_mem_wr     (memWr),
    .o_mem_wdata  (memWdata),
    .i_mem_rdata  (memRdata)
  );

  always #5 clk = ~clk;

  // Word memory: one-cycle read latency, garbage on the bus when not reading
  // so that a mistimed capture shows up.
  always @(posedge clk) begin
    if (memRd && memAddr < 32'd256) begin
      memRdata <= mem[memAddr[7:0]];
    end else begin
      memRdata <= $urandom;
    end
    if (pokeEn) begin
      mem[pokeIdx] <= pokeVal;
    end else if (memWr && memAddr < 32'd256) begin
      mem[memAddr[7:0]] <= memWdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: little-endian byte memory, plain arithmetic.
  function automatic exp_t refModel(input logic we, input logic [1:0] size,
                                    input logic sgn, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    exp_t        e;
    int          n;
    int          base;
    logic [31:0] v;
    e.rdata     = 32'h0;
    e.fault     = 1'b0;
    e.lat       = 1;
    e.acceptCyc = 0;
    e.rdCnt     = 0;
    e.wrCnt     = 0;
    e.wordIdx   = addr / 4;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (size == 2'b11 || (addr % n) != 0 || (addr / 4) >= 256) begin
      e.fault = 1'b1;
      return e;
    end
    base = int'(addr);
    if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
        v = v | (32'(refMem[base + i]) << (8 * i));
      end
      if (sgn && n < 4 && v[8 * n - 1]) begin
        v = v | ~((32'h1 << (8 * n)) - 32'h1);
      end
      e.rdata = v;
      e.lat   = 3;
      e.rdCnt = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        refMem[base + i] = wdata[8 * i +: 8];
      end
      e.wrCnt = 1;
      e.rdCnt = (n == 4) ? 0 : 1;
      e.lat   = (n == 4) ? 2 : 4;
    end
    return e;
  endfunction

  // Monitor: counts strobes, checks addresses and pops the scoreboard on
  // every response.
  always @(negedge clk) begin
    exp_t e;
    negCount++;
    if (rst) begin
      rdSeen = 0;
      wrSeen = 0;
    end else begin
      if (memRd || memWr) begin
        checkOutput("strobe_exclusive", {31'b0, memRd & memWr}, 32'h0);
        checkOutput("idle_resp_rdata", respRdata, 32'h0);
        if (sbQ.size() > 0) begin
          checkOutput("mem_addr", memAddr, sbQ[0].wordIdx);
        end
      end
      if (memRd) rdSeen++;
      if (memWr) wrSeen++;
      if (respValid) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
        end else begin
          e = sbQ.pop_front();
          checkOutput("resp_rdata", respRdata, e.rdata);
          checkOutput("resp_fault", {31'b0, respFault}, {31'b0, e.fault});
          checkOutput("latency", negCount - e.acceptCyc, e.lat);
          checkOutput("mem_rd_count", rdSeen, e.rdCnt);
          checkOutput("mem_wr_count", wrSeen, e.wrCnt);
        end
        rdSeen = 0;
        wrSeen = 0;
      end
    end
  end

  task automatic pokeWord(input int idx, input logic [31:0] val);
    for (int i = 0; i < 4; i++) begin
      refMem[4 * idx + i] = val[8 * i +: 8];
    end
    pokeIdx = idx[7:0];
    pokeVal = val;
    pokeEn  = 1'b1;
    @(posedge clk);
    #1 pokeEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while (!reqReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!reqReady) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout: got req_ready=0, expected 1 within 50 cycles");
      return;
    end
    reqValid  = 1'b1;
    reqWe     = we;
    reqSize   = size;
    reqSigned = sgn;
    reqAddr   = addr;
    reqWdata  = wdata;
    @(posedge clk);
    e = refModel(we, size, sgn, addr, wdata);
    e.acceptCyc = negCount;
    sbQ.push_back(e);
    #1;
    reqValid = 1'b0;
    reqWdata = $urandom;
    reqAddr  = $urandom;
  endtask

  task automatic waitDrain();
    int guard = 0;
    @(negedge clk);
    while ((sbQ.size() != 0 || !reqReady) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sbQ.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus: reset, directed cases, reset mid-op, then random traffic.
  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    rst       = 1'b1;
    reqValid  = 1'b1;
    reqWe     = 1'b0;
    reqSize   = 2'b10;
    reqSigned = 1'b0;
    reqAddr   = 32'h8;
    reqWdata  = 32'h0;
    for (int w = 0; w < 256; w++) begin
      pokeWord(w, $urandom);
    end
    @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, reqReady}, 32'h0);
    checkOutput("rst_resp_valid", {31'b0, respValid}, 32'h0);
    checkOutput("rst_mem_rd", {31'b0, memRd}, 32'h0);
    checkOutput("rst_mem_wr", {31'b0, memWr}, 32'h0);
    checkOutput("rst_mem_addr", memAddr, 32'h0);
    checkOutput("rst_resp_rdata", respRdata, 32'h0);
    reqValid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'b0, reqReady}, 32'h1);

    pokeWord(2, 32'hDEADBEEF);
    pokeWord(1, 32'h11223344);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h8, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AA);
    waitDrain();
    checkOutput("sb_merge", mem[1], 32'h1122AA44);
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h4, 32'hCAFEF00D);
    waitDrain();
    checkOutput("sw_word", mem[1], 32'hCAFEF00D);
    pokeWord(1, 32'h11223344);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h6, 32'h00001234);
    waitDrain();
    checkOutput("sh_merge", mem[1], 32'h12343344);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h3, 32'h0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    waitDrain();

    // Reset asserted while the half store sits in CAP: the store is dropped.
    pokeWord(0, 32'h55667788);
    @(negedge clk);
    reqValid  = 1'b1;
    reqWe     = 1'b1;
    reqSize   = 2'b01;
    reqSigned = 1'b0;
    reqAddr   = 32'h2;
    reqWdata  = 32'h0000BEEF;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rst_mid_mem_wr", {31'b0, memWr}, 32'h0);
      checkOutput("rst_mid_resp_valid", {31'b0, respValid}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ready", {31'b0, reqReady}, 32'h1);
    checkOutput("rst_mid_mem", mem[0], 32'h55667788);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    waitDrain();

    // Random traffic, biased towards aligned in-range accesses.
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      r  = $urandom_range(0, 19);
      if (r == 0) begin
        a = $urandom;
      end else if (r == 1) begin
        a = 32'h400 + 32'($urandom_range(0, 15));
      end else begin
        a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'b01) a[0] = 1'b0;
          if (sz == 2'b10) a[1:0] = 2'b00;
        end
      end
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain();

    for (int w = 0; w < 256; w++) begin
      checkOutput($sformatf("mem_word_%0d", w), mem[w],
                  {refMem[4 * w + 3], refMem[4 * w + 2], refMem[4 * w + 1], refMem[4 * w]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: sits in the MEM stage between the pipeline and the word-addressed data memory.
- Accepts one byte/half/word load or store request at a time and converts the byte address to a word index.
- Performs sub-word stores as read-modify-write and sign/zero-extends sub-word loads.
- Flags misaligned and out-of-range accesses as faults without touching memory.

Parameters:
MEM_WORDS, 256, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range
MEM_RD_LATENCY, 1, cycles from mem_rd assertion to valid mem_rdata; fixed at 1 for this revision

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores and faults
resp_fault  out  1  valid with resp_valid: misaligned, illegal size or out of range
mem_addr  out  32  word index = captured req_addr[31:2]
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_wdata  out  32  full word written when mem_wr = 1
mem_rdata  in  32  memory read data, valid the cycle after mem_rd

Behaviour:
- Reset values: all outputs 0, state IDLE, internal registers 0. req_ready is 0 while rst = 1.
- Clock and reset: single clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- States:
  - IDLE: req_ready = 1.
  - RD: mem_rd = 1.
  - CAP: captures mem_rdata.
  - WR: mem_wr = 1.
  - RESP: resp_valid = 1.
- Accept: on a clk edge with req_valid && req_ready, the unit captures we, size, signed, addr and wdata. Request inputs are ignored at all other times.
- Fault check at accept: size = 11, half with addr[0] = 1, word with addr[1:0] != 0, or addr[31:2] >= MEM_WORDS. On a fault the unit goes IDLE -> RESP with resp_fault = 1 and resp_rdata = 0; mem_rd and mem_wr are never asserted.
- Load paths and latency (resp_valid high N cycles after the accept edge):
  - Load: IDLE -> RD -> CAP -> RESP, latency 3.
  - Fault: latency 1.
- Store paths and latency:
  - Word store: IDLE -> WR -> RESP, latency 2. mem_wdata = req_wdata.
  - Byte/half store: IDLE -> RD -> CAP -> WR -> RESP, latency 4. mem_wdata = read word with the target lane(s) replaced.
- Byte lanes are little-endian:
  - Byte offset k occupies bits [8k+7:8k].
  - Half at offset 0 occupies [15:0]; half at offset 2 occupies [31:16].
- Load extraction: the selected lane is shifted to bit 0, then sign-extended (req_signed = 1) or zero-extended. A word load returns mem_rdata unchanged; req_signed is ignored for words and for stores.
- Strobes and address stability:
  - mem_rd and mem_wr are Moore outputs of state and are never high together.
  - Each strobe is high for exactly one cycle per access.
  - mem_addr is valid from RD/WR entry and held stable through RESP.
- Response:
  - resp_valid is high for exactly one cycle and has no backpressure.
  - RESP -> IDLE unconditionally; a new request can be accepted in the cycle after RESP.
  - resp_rdata and resp_fault are valid only while resp_valid = 1 and are 0 otherwise.
- Throughput: at most one outstanding request; no request is accepted outside IDLE.
- Reset mid-operation: rst = 1 in any state forces IDLE on that edge, deasserts all strobes and discards the in-flight request. A dropped store produces no partial write and no response.
- rst dominates a simultaneous req_valid.

Test Plan:
1. Word load: mem word 2 = 0xDEADBEEF, req load word addr 0x8 -> mem_rd for one cycle with mem_addr = 2; resp_valid 3 cycles after accept with resp_rdata = 0xDEADBEEF, resp_fault = 0.
2. Sub-word loads, same word:
   - lb signed addr 0x9 -> 0xFFFFFFBE.
   - lbu addr 0x9 -> 0x000000BE.
   - lh signed addr 0xA -> 0xFFFFDEAD.
   - lhu addr 0x8 -> 0x0000BEEF.
3. Byte store: mem word 1 = 0x11223344, sb addr 0x5 wdata 0x000000AA -> mem_rd, then mem_wr with mem_addr = 1 and mem_wdata = 0x1122AA44; resp_valid 4 cycles after accept.
4. Stores, word and half:
   - sw addr 0x4 wdata 0xCAFEF00D -> no mem_rd; mem_wr in the cycle after accept with data 0xCAFEF00D; resp 2 cycles after accept.
   - sh addr 0x6 wdata 0x1234 on word 0x11223344 -> mem_wdata = 0x12343344.
5. Faults: each case gives resp_valid + resp_fault one cycle after accept, resp_rdata = 0, and zero mem_rd/mem_wr activity.
   - sw addr 0x6.
   - lh addr 0x3.
   - size = 11.
   - lw addr 0x400 (word 256).
6. Reset mid-op:
   - sh addr 0x2 with rst asserted in CAP -> no mem_wr, no resp_valid, memory unchanged.
   - After rst deasserts, req_ready = 1 and a following lw completes normally.
